stereo_pixel_mixer: RTL and testbench
=====================================

// Module: stereo_pixel_mixer
// PURPOSE
//  Registered output stage between the stereo pixel paths and the VGA DAC pins.
//  Takes one left and one right PIX_W-bit grey sample per clock and expands each to OUT_W bits.
//  Combines them per a frame-latched mode and drives R/G/B with blanking applied.
//  Delays hsync/vsync/nblank by the same latency so sync stays pixel-aligned.
// PARAMETERS
//  PIX_W   4   input sample width per eye (1..OUT_W)
//  OUT_W   8   output width per colour channel
//  VS_POL  0   active level of vsync (0 = active-low)
//  BAR_W   80  test-pattern bar width in pixels (MIX_TPG_EN only)
// PORTS
//  clk       in   1      pixel clock
//  rst_n     in   1      reset, synchronous, active-low
//  din_l     in   PIX_W  left-eye sample
//  din_r     in   PIX_W  right-eye sample
//  nblank    in   1      1 = active video
//  hsync_i   in   1      horizontal sync, aligned with din_*
//  vsync_i   in   1      vertical sync, aligned with din_*
//  mode_sel  in   2      requested mix mode (sampled at frame start)
//  tpg_on    in   1      test-pattern request (ignored unless MIX_TPG_EN)
//  r,g,b     out  OUT_W  colour outputs
//  hsync_o   out  1      hsync delayed by 2 clocks
//  vsync_o   out  1      vsync delayed by 2 clocks
//  mode_cur  out  2      mode currently applied
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge clk): r=g=b=0, hsync_o=vsync_o=~VS_POL, mode_cur=0, all pipe regs 0.
//  - Expansion: e(x) = x replicated MSB-first to fill OUT_W (4'hA -> 8'hAA; PIX_W=3, 3'b101 -> 8'b10110110).
//  - Stage 1 registers e(din_l), e(din_r), nblank, hsync_i, vsync_i. Stage 2 registers outputs.
//  - Latency: exactly 2 clocks, data and sync together.
//  - Modes on mode_cur:
//    - 0 AVG: r=g=b=(e_l+e_r)>>1, sum in OUT_W+1 bits, truncated.
//    - 1 LEFT: r=g=b=e_l.
//    - 2 RIGHT: r=g=b=e_r.
//    - 3 ANAGLYPH: r=e_l, g=b=e_r.
//  - Mode latch: mode_cur <= mode_sel on the clock where vsync_i transitions to VS_POL (frame-start edge).
//    - Detection uses a registered previous-vsync bit; that bit resets to the inactive level.
//    - mode_sel changes mid-frame have no effect until the next frame-start edge.
//    - A new mode applies to the pixel entering stage 1 on the latching clock and to all later pixels.
//  - Blanking: stage-1 nblank=0 -> stage 2 drives r=g=b=0 regardless of mode.
//  - Reset mid-frame: pipe flushes to reset values next clock, mode_cur=0.
//    - After reset, the first frame-start edge is required before any mode other than 0 applies.
// CONFIGURATION
//  MIX_TPG_EN defined:
//    - 10-bit pixel counter px: cleared when nblank=0, incremented each active pixel, saturates at 1023.
//    - When tpg_on=1 the AVG/mode path is replaced by 8 vertical bars.
//      - bar = (px / BAR_W) mod 8; bit2/bit1/bit0 select R/G/B full scale ({OUT_W{1'b1}}) or 0.
//    - tpg_on is sampled per pixel; latency and blanking are unchanged.
//  MIX_TPG_EN undefined:
//    - Counter and bar logic absent; tpg_on has no effect.
// TESTING (PIX_W=4, OUT_W=8, VS_POL=0)
//  1. Hold rst_n=0 for 3 clks with active inputs -> r=g=b=0, hsync_o=vsync_o=1, mode_cur=0.
//  2. Mode 0, din_l=A, din_r=4, nblank=1 -> r=g=b=8'h77 exactly 2 clks later; hsync_o follows hsync_i by 2 clks.
//  3. mode_sel=3 mid-frame -> output stays AVG; after vsync_i falls: mode_cur=3, r=8'hAA, g=b=8'h44.
//  4. nblank=0 for one pixel inside active stream -> r=g=b=0 on that cycle only; neighbours unaffected.
//  5. din_l=F, din_r=F, mode 0 -> 8'hFF (no overflow); din_l=0, din_r=1 -> 8'h08.
//  6. MIX_TPG_EN, tpg_on=1, BAR_W=80: px 0..79 -> 000000; px 80..159 -> 0000FF; px 560+ -> FFFFFF.

Source files
------------

// File: rtl/stereo_pixel_mixer.sv
// ---------------------------------------------------------------------------
// stereo_pixel_mixer
// Registered output stage between the stereo pixel paths and the VGA DAC pins.
// Expands one left and one right grey sample per clock to OUT_W bits, combines
// them according to a mode latched at frame start, and applies blanking. The
// hsync/vsync pins are delayed by the same two clocks as the pixel data.
//
// Optional feature macro: MIX_TPG_EN (8-bar vertical test pattern generator).
//
// Ports
//   clk       in   1      pixel clock
//   rst_n     in   1      synchronous active-low reset
//   din_l     in   PIX_W  left-eye sample
//   din_r     in   PIX_W  right-eye sample
//   nblank    in   1      1 = active video
//   hsync_i   in   1      horizontal sync, aligned with din_*
//   vsync_i   in   1      vertical sync, aligned with din_*
//   mode_sel  in   2      requested mix mode (taken at frame start)
//   tpg_on    in   1      test-pattern request (no effect without MIX_TPG_EN)
//   r,g,b     out  OUT_W  colour outputs
//   hsync_o   out  1      hsync delayed by 2 clocks
//   vsync_o   out  1      vsync delayed by 2 clocks
//   mode_cur  out  2      mode currently applied
// ---------------------------------------------------------------------------
module stereo_pixel_mixer #(
  parameter int unsigned PIX_W  = 4,
  parameter int unsigned OUT_W  = 8,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned BAR_W  = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] din_l,
  input  logic [PIX_W-1:0] din_r,
  input  logic             nblank,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic [1:0]       mode_sel,
  input  logic             tpg_on,
  output logic [OUT_W-1:0] r,
  output logic [OUT_W-1:0] g,
  output logic [OUT_W-1:0] b,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic [1:0]       mode_cur
);

  typedef enum logic [1:0] {
    MODE_AVG   = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_ANA   = 2'd3
  } mode_e;

  // Sync pins idle at the inactive vsync level out of reset.
  localparam logic SYNC_IDLE = ~VS_POL;

  // Replicate the sample MSB-first until OUT_W bits are filled.
  function automatic logic [OUT_W-1:0] expand(input logic [PIX_W-1:0] x);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(OUT_W); i++) begin
      v[int'(OUT_W) - 1 - i] = x[int'(PIX_W) - 1 - (i % int'(PIX_W))];
    end
    return v;
  endfunction

  // Stage 1 registers
  logic [OUT_W-1:0] r_s1_l;
  logic [OUT_W-1:0] r_s1_r;
  logic             r_s1_nb;
  logic             r_s1_hs;
  logic             r_s1_vs;
  mode_e            r_s1_mode;

  // Frame-start detection and applied mode
  logic             r_vs_prev;
  mode_e            r_mode_cur;

  // Stage 2 (output) registers
  logic [OUT_W-1:0] r_r;
  logic [OUT_W-1:0] r_g;
  logic [OUT_W-1:0] r_b;
  logic             r_hs_o;
  logic             r_vs_o;

  // Stage 2 next values
  logic [OUT_W-1:0] w_r;
  logic [OUT_W-1:0] w_g;
  logic [OUT_W-1:0] w_b;
  logic [OUT_W:0]   w_sum;
  logic [OUT_W-1:0] w_avg;

  logic             w_frame_start;
  mode_e            w_mode_next;

  // Frame start is the clock where vsync_i enters its active level.
  assign w_frame_start = (vsync_i == VS_POL) && (r_vs_prev != VS_POL);
  // The newly latched mode applies to the pixel entering on the same clock.
  assign w_mode_next   = w_frame_start ? mode_e'(mode_sel) : r_mode_cur;

`ifdef MIX_TPG_EN
  logic [9:0] r_px;
  logic       r_s1_tpg;
  logic [2:0] r_s1_bar;
  logic [2:0] w_bar;

  assign w_bar = 3'(32'(r_px) / BAR_W);

  // Active-pixel counter, cleared in blanking, saturating at 1023.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_px     <= '0;
      r_s1_tpg <= 1'b0;
      r_s1_bar <= '0;
    end else begin
      r_s1_tpg <= tpg_on;
      r_s1_bar <= w_bar;
      if (!nblank) begin
        r_px <= '0;
      end else if (r_px != 10'h3FF) begin
        r_px <= r_px + 10'd1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = tpg_on | (BAR_W == 0);
`endif

  // Stage 1: expand samples, carry blank/sync/mode alongside the pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_l     <= '0;
      r_s1_r     <= '0;
      r_s1_nb    <= 1'b0;
      r_s1_hs    <= SYNC_IDLE;
      r_s1_vs    <= SYNC_IDLE;
      r_s1_mode  <= MODE_AVG;
      r_vs_prev  <= SYNC_IDLE;
      r_mode_cur <= MODE_AVG;
    end else begin
      r_s1_l     <= expand(din_l);
      r_s1_r     <= expand(din_r);
      r_s1_nb    <= nblank;
      r_s1_hs    <= hsync_i;
      r_s1_vs    <= vsync_i;
      r_s1_mode  <= w_mode_next;
      r_vs_prev  <= vsync_i;
      r_mode_cur <= w_mode_next;
    end
  end

  assign w_sum = {1'b0, r_s1_l} + {1'b0, r_s1_r};
  assign w_avg = w_sum[OUT_W:1];

  // Stage 2 colour selection with blanking.
  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (r_s1_nb) begin
      unique case (r_s1_mode)
        MODE_AVG:   begin w_r = w_avg;  w_g = w_avg;  w_b = w_avg;  end
        MODE_LEFT:  begin w_r = r_s1_l; w_g = r_s1_l; w_b = r_s1_l; end
        MODE_RIGHT: begin w_r = r_s1_r; w_g = r_s1_r; w_b = r_s1_r; end
        MODE_ANA:   begin w_r = r_s1_l; w_g = r_s1_r; w_b = r_s1_r; end
        default:    begin w_r = '0;     w_g = '0;     w_b = '0;     end
      endcase
`ifdef MIX_TPG_EN
      if (r_s1_tpg) begin
        w_r = {OUT_W{r_s1_bar[2]}};
        w_g = {OUT_W{r_s1_bar[1]}};
        w_b = {OUT_W{r_s1_bar[0]}};
      end
`endif
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
      r_hs_o <= SYNC_IDLE;
      r_vs_o <= SYNC_IDLE;
    end else begin
      r_r    <= w_r;
      r_g    <= w_g;
      r_b    <= w_b;
      r_hs_o <= r_s1_hs;
      r_vs_o <= r_s1_vs;
    end
  end

  assign r        = r_r;
  assign g        = r_g;
  assign b        = r_b;
  assign hsync_o  = r_hs_o;
  assign vsync_o  = r_vs_o;
  assign mode_cur = r_mode_cur;

endmodule

// File: tb/tb_stereo_pixel_mixer.sv
// ---------------------------------------------------------------------------
// tb_stereo_pixel_mixer
// Directed-vector bench for stereo_pixel_mixer (PIX_W=4, OUT_W=8, VS_POL=0).
// Inputs change 1ns after the rising edge; outputs are checked at that point,
// i.e. after the registers have settled from the preceding edge.
// ---------------------------------------------------------------------------
module tb_stereo_pixel_mixer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din_l;
  logic [3:0] din_r;
  logic       nblank;
  logic       hsync_i;
  logic       vsync_i;
  logic [1:0] mode_sel;
  logic       tpg_on;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hsync_o;
  logic       vsync_o;
  logic [1:0] mode_cur;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stereo_pixel_mixer #(
    .PIX_W (4),
    .OUT_W (8),
    .VS_POL(1'b0),
    .BAR_W (80)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_l   (din_l),
    .din_r   (din_r),
    .nblank  (nblank),
    .hsync_i (hsync_i),
    .vsync_i (vsync_i),
    .mode_sel(mode_sel),
    .tpg_on  (tpg_on),
    .r       (r),
    .g       (g),
    .b       (b),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .mode_cur(mode_cur)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] l, input logic [3:0] rr, input logic nb,
                       input logic hs, input logic vs, input logic [1:0] ms);
    din_l = l; din_r = rr; nblank = nb; hsync_i = hs; vsync_i = vs; mode_sel = ms;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tpg_on = 1'b0;
    drive(4'hA, 4'h4, 1'b1, 1'b0, 1'b0, 2'd3);
    step(); step(); step();
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL reset_r got %h exp 00", r); end
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL reset_g got %h exp 00", g); end
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL reset_b got %h exp 00", b); end
    checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync_o); end
    checks++; if (vsync_o !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync_o); end
    checks++; if (mode_cur !== 2'd0) begin errors++; $display("FAIL reset_mode got %0d exp 0", mode_cur); end
    drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_avg();
    // Frame start with mode 0, blanked pixel.
    drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0); step();
    drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0); step();
    drive(4'hA, 4'h4, 1'b1, 1'b0, 1'b1, 2'd0); step();
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL avg_lat1_r got %h exp 00", r); end
    checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL avg_lat1_hs got %b exp 1", hsync_o); end
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b1, 2'd0); step();
    checks++; if (r !== 8'h77) begin errors++; $display("FAIL avg_r got %h exp 77", r); end
    checks++; if (g !== 8'h77) begin errors++; $display("FAIL avg_g got %h exp 77", g); end
    checks++; if (b !== 8'h77) begin errors++; $display("FAIL avg_b got %h exp 77", b); end
    checks++; if (hsync_o !== 1'b0) begin errors++; $display("FAIL avg_hs_lat2 got %b exp 0", hsync_o); end
    step();
    checks++; if (hsync_o !== 1'b1) begin errors++; $display("FAIL avg_hs_next got %b exp 1", hsync_o); end
    checks++; if (vsync_o !== 1'b1) begin errors++; $display("FAIL avg_vs got %b exp 1", vsync_o); end
  endtask

  task automatic test_mode_latch();
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b1, 2'd3); step(); step();
    checks++; if (mode_cur !== 2'd0) begin errors++; $display("FAIL midframe_mode got %0d exp 0", mode_cur); end
    checks++; if (g !== 8'h77) begin errors++; $display("FAIL midframe_g got %h exp 77", g); end
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b0, 2'd3); step();
    checks++; if (mode_cur !== 2'd3) begin errors++; $display("FAIL latch_mode got %0d exp 3", mode_cur); end
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b1, 2'd0); step();
    checks++; if (r !== 8'hAA) begin errors++; $display("FAIL ana_r got %h exp AA", r); end
    checks++; if (g !== 8'h44) begin errors++; $display("FAIL ana_g got %h exp 44", g); end
    checks++; if (b !== 8'h44) begin errors++; $display("FAIL ana_b got %h exp 44", b); end
    checks++; if (vsync_o !== 1'b0) begin errors++; $display("FAIL ana_vs got %b exp 0", vsync_o); end
    step();
    checks++; if (mode_cur !== 2'd3) begin errors++; $display("FAIL hold_mode got %0d exp 3", mode_cur); end
    checks++; if (r !== 8'hAA) begin errors++; $display("FAIL hold_r got %h exp AA", r); end
  endtask

  task automatic test_blank();
    drive(4'h5, 4'h9, 1'b1, 1'b1, 1'b1, 2'd0); step();
    drive(4'h5, 4'h9, 1'b0, 1'b1, 1'b1, 2'd0); step();
    checks++; if (r !== 8'h55 || g !== 8'h99) begin errors++; $display("FAIL blank_pre got %h/%h exp 55/99", r, g); end
    drive(4'h5, 4'h9, 1'b1, 1'b1, 1'b1, 2'd0); step();
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL blank_r got %h exp 00", r); end
    checks++; if (g !== 8'h00) begin errors++; $display("FAIL blank_g got %h exp 00", g); end
    checks++; if (b !== 8'h00) begin errors++; $display("FAIL blank_b got %h exp 00", b); end
    drive(4'hC, 4'h3, 1'b1, 1'b1, 1'b1, 2'd0); step();
    checks++; if (r !== 8'h55 || b !== 8'h99) begin errors++; $display("FAIL blank_post got %h/%h exp 55/99", r, b); end
    step();
    checks++; if (r !== 8'hCC || g !== 8'h33) begin errors++; $display("FAIL blank_next got %h/%h exp CC/33", r, g); end
  endtask

  task automatic test_extremes();
    drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 2'd0); step();
    checks++; if (mode_cur !== 2'd0) begin errors++; $display("FAIL ext_mode got %0d exp 0", mode_cur); end
    drive(4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0); step();
    drive(4'h0, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0); step();
    checks++; if (r !== 8'hFF || g !== 8'hFF || b !== 8'hFF) begin errors++; $display("FAIL ext_max got %h%h%h exp FFFFFF", r, g, b); end
    step();
    checks++; if (r !== 8'h08 || g !== 8'h08 || b !== 8'h08) begin errors++; $display("FAIL ext_min got %h%h%h exp 080808", r, g, b); end
  endtask

  task automatic test_reset_mid();
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b0, 2'd1); step();
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b1, 2'd1); step();
    checks++; if (r !== 8'hAA || g !== 8'hAA || b !== 8'hAA) begin errors++; $display("FAIL left_mode got %h%h%h exp AAAAAA", r, g, b); end
    rst_n = 1'b0; step();
    checks++; if (r !== 8'h00 || mode_cur !== 2'd0) begin errors++; $display("FAIL rstmid got r=%h mode=%0d exp 00/0", r, mode_cur); end
    rst_n = 1'b1;
    drive(4'hA, 4'h4, 1'b1, 1'b1, 1'b1, 2'd3); step(); step();
    checks++; if (r !== 8'h77 || g !== 8'h77) begin errors++; $display("FAIL rstmid_avg got %h/%h exp 77/77", r, g); end
    checks++; if (mode_cur !== 2'd0) begin errors++; $display("FAIL rstmid_mode got %0d exp 0", mode_cur); end
  endtask

`ifdef MIX_TPG_EN
  task automatic test_tpg();
    logic [23:0] got;
    drive(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0); tpg_on = 1'b1; step();
    for (int i = 0; i < 602; i++) begin
      drive(4'h3, 4'h7, (i < 600) ? 1'b1 : 1'b0, 1'b1, 1'b1, 2'd0);
      step();
      got = {r, g, b};
      if (i - 1 == 0 || i - 1 == 79) begin
        checks++; if (got !== 24'h000000) begin errors++; $display("FAIL tpg_bar0 px=%0d got %h exp 000000", i - 1, got); end
      end
      if (i - 1 == 80 || i - 1 == 159) begin
        checks++; if (got !== 24'h0000FF) begin errors++; $display("FAIL tpg_bar1 px=%0d got %h exp 0000FF", i - 1, got); end
      end
      if (i - 1 == 560 || i - 1 == 599) begin
        checks++; if (got !== 24'hFFFFFF) begin errors++; $display("FAIL tpg_bar7 px=%0d got %h exp FFFFFF", i - 1, got); end
      end
    end
    tpg_on = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_avg();
    test_mode_latch();
    test_blank();
    test_extremes();
    test_reset_mid();
`ifdef MIX_TPG_EN
    test_tpg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
